// File: rtl/led_pkg.sv
// Shared types and constant helpers for the row-scanned LED matrix driver.
package led_pkg;

    // Scanner states: parked, inter-row blanking, row being driven.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so every counter/index has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Inactive drive level for a bus of the given width: all-ones when the
    // pins are active-low, all-zeros otherwise. Buses wider than 64 are not supported.
    function automatic logic [63:0] inactive_level(input int act_low, input int width);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width && act_low != 0) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Bitmap/brightness inputs and matrix pin outputs of the LED scanner.
interface led_matrix_scan_if
    import led_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int BRIGHT_BITS = 2
) ();

    localparam int RW = clog2(ROWS);

    logic                   OE;
    logic [ROWS*COLS-1:0]   data;
    logic [BRIGHT_BITS-1:0] brightness;
    logic [ROWS-1:0]        row;
    logic [COLS-1:0]        column;
    logic [RW-1:0]          row_idx;
    logic                   frame_start;

    modport master (
        output OE, data, brightness,
        input  row, column, row_idx, frame_start
    );

    modport slave (
        input  OE, data, brightness,
        output row, column, row_idx, frame_start
    );

endinterface

// File: rtl/led_pwm_cmp.sv
// Dwell counter for one driven row plus the brightness compare that gates
// the columns. gate_next refers to the dwell cycle the counter moves into
// at the coming edge, so the registered column output lines up with it.
module led_pwm_cmp #(
    parameter int BRIGHT_BITS = 2
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   advance,
    input  logic [BRIGHT_BITS-1:0] bright,
    output logic                   last,
    output logic                   gate_next
);

    localparam logic [BRIGHT_BITS-1:0] CNT_MAX = '1;
    localparam logic [BRIGHT_BITS-1:0] CNT_ONE = BRIGHT_BITS'(1);

    logic [BRIGHT_BITS-1:0] dwell_cnt;
    logic [BRIGHT_BITS-1:0] cnt_next;

    // Next dwell index: restart on row entry or scanner park, step while driving.
    // The count wraps to 0 on its own after the last dwell cycle.
    always_comb begin
        cnt_next = dwell_cnt;
        if (clear || start) begin
            cnt_next = '0;
        end else if (advance) begin
            cnt_next = dwell_cnt + CNT_ONE;
        end
    end

    // Dwell counter register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= cnt_next;
        end
    end

    assign last      = advance && (dwell_cnt == CNT_MAX);
    assign gate_next = (cnt_next <= bright);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanned LED matrix driver: one row lit at a time, bitmap and brightness
// latched at each frame start, blank gap before every row, PWM column gating.
module led_matrix_scan
    import led_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int BRIGHT_BITS = 2,
    parameter int BLANK       = 1,
    parameter int ROW_ACT_LOW = 0,
    parameter int COL_ACT_LOW = 0
) (
    input logic              CLK,
    input logic              RSTn,
    led_matrix_scan_if.slave bus
);

    localparam int RW = clog2(ROWS);
    localparam int BW = clog2(BLANK);

    localparam logic [63:0]     ROW_OFF_W = inactive_level(ROW_ACT_LOW, ROWS);
    localparam logic [63:0]     COL_OFF_W = inactive_level(COL_ACT_LOW, COLS);
    localparam logic [ROWS-1:0] ROW_OFF   = ROW_OFF_W[ROWS-1:0];
    localparam logic [COLS-1:0] COL_OFF   = COL_OFF_W[COLS-1:0];
    localparam logic [ROWS-1:0] ROW_ONE   = ROWS'(1);

    localparam logic [RW-1:0] IDX_LAST   = RW'(ROWS - 1);
    localparam logic [RW-1:0] IDX_ONE    = RW'(1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);
    localparam logic [BW-1:0] BLANK_ONE  = BW'(1);

    state_t                 state;
    logic [BW-1:0]          blank_cnt;
    logic [RW-1:0]          row_idx_q;
    logic [ROWS*COLS-1:0]   shadow;
    logic [BRIGHT_BITS-1:0] bright_q;
    logic [ROWS-1:0]        row_q;
    logic [COLS-1:0]        column_q;
    logic                   frame_start_q;

    logic [COLS-1:0] row_bits;
    logic            blank_done;
    logic            pwm_clear;
    logic            pwm_start;
    logic            pwm_advance;
    logic            pwm_last;
    logic            pwm_gate;

    assign row_bits    = shadow[row_idx_q*COLS +: COLS];
    assign blank_done  = (state == ST_BLANK) && (blank_cnt == BLANK_LAST);
    assign pwm_clear   = !bus.OE;
    assign pwm_start   = bus.OE && blank_done;
    assign pwm_advance = bus.OE && (state == ST_DRIVE);

    led_pwm_cmp #(
        .BRIGHT_BITS(BRIGHT_BITS)
    ) u_pwm (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .clear     (pwm_clear),
        .start     (pwm_start),
        .advance   (pwm_advance),
        .bright    (bright_q),
        .last      (pwm_last),
        .gate_next (pwm_gate)
    );

    // Scanner FSM with registered pin outputs; outputs for a state are set on
    // the same edge that enters it. Frame start (entering BLANK at row 0)
    // is the only place the shadow bitmap and brightness are reloaded.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state         <= ST_IDLE;
            blank_cnt     <= '0;
            row_idx_q     <= '0;
            shadow        <= '0;
            bright_q      <= '0;
            row_q         <= ROW_OFF;
            column_q      <= COL_OFF;
            frame_start_q <= 1'b0;
        end else if (!bus.OE) begin
            state         <= ST_IDLE;
            blank_cnt     <= '0;
            row_idx_q     <= '0;
            row_q         <= ROW_OFF;
            column_q      <= COL_OFF;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state         <= ST_BLANK;
                    blank_cnt     <= '0;
                    shadow        <= bus.data;
                    bright_q      <= bus.brightness;
                    frame_start_q <= 1'b1;
                    row_q         <= ROW_OFF;
                    column_q      <= COL_OFF;
                end
                ST_BLANK: begin
                    if (blank_done) begin
                        state     <= ST_DRIVE;
                        blank_cnt <= '0;
                        row_q     <= (ROW_ONE << row_idx_q) ^ ROW_OFF;
                        column_q  <= pwm_gate ? (row_bits ^ COL_OFF) : COL_OFF;
                    end else begin
                        blank_cnt <= blank_cnt + BLANK_ONE;
                    end
                end
                ST_DRIVE: begin
                    if (pwm_last) begin
                        state     <= ST_BLANK;
                        blank_cnt <= '0;
                        row_q     <= ROW_OFF;
                        column_q  <= COL_OFF;
                        if (row_idx_q == IDX_LAST) begin
                            row_idx_q     <= '0;
                            shadow        <= bus.data;
                            bright_q      <= bus.brightness;
                            frame_start_q <= 1'b1;
                        end else begin
                            row_idx_q <= row_idx_q + IDX_ONE;
                        end
                    end else begin
                        column_q <= pwm_gate ? (row_bits ^ COL_OFF) : COL_OFF;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    blank_cnt <= '0;
                    row_idx_q <= '0;
                    row_q     <= ROW_OFF;
                    column_q  <= COL_OFF;
                end
            endcase
        end
    end

    assign bus.row         = row_q;
    assign bus.column      = column_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: an active-high and an active-low build share
// stimulus; a frame-position model predicts each cycle's outputs.
module tb_led_matrix_scan;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int BB     = 2;
    localparam int BLANK  = 1;
    localparam int DWELL  = 4;
    localparam int SEG    = BLANK + DWELL;
    localparam int PERIOD = ROWS * SEG;

    localparam logic [63:0] DIAG = 64'h8040201008040201;

    logic        CLK = 1'b0;
    logic        rstn;
    logic        oe;
    logic [63:0] data;
    logic [1:0]  bright;

    // Free-running clock.
    always #5 CLK = ~CLK;

    led_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS), .BRIGHT_BITS(BB)) bus_h ();
    led_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS), .BRIGHT_BITS(BB)) bus_l ();

    assign bus_h.OE         = oe;
    assign bus_h.data       = data;
    assign bus_h.brightness = bright;
    assign bus_l.OE         = oe;
    assign bus_l.data       = data;
    assign bus_l.brightness = bright;

    led_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .BRIGHT_BITS(BB), .BLANK(BLANK),
        .ROW_ACT_LOW(0), .COL_ACT_LOW(0)
    ) dut_h (
        .CLK  (CLK),
        .RSTn (rstn),
        .bus  (bus_h)
    );

    led_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .BRIGHT_BITS(BB), .BLANK(BLANK),
        .ROW_ACT_LOW(1), .COL_ACT_LOW(1)
    ) dut_l (
        .CLK  (CLK),
        .RSTn (rstn),
        .bus  (bus_l)
    );

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic [2:0] idx;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [1:0]  bright;
        logic [63:0] data;
        int          exp_lit;
        logic [7:0]  exp_col;
    } pwm_vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    bit          running  = 1'b0;
    int          t        = 0;
    logic [63:0] shadow_m = '0;
    logic [1:0]  bright_m = '0;

    // Predict the outputs after the coming edge from the position within the frame.
    function automatic exp_t model_next();
        exp_t e;
        int   r;
        int   w;
        int   d;
        e = '0;
        if (!rstn) begin
            running  = 1'b0;
            shadow_m = '0;
            bright_m = '0;
        end else if (!oe) begin
            running = 1'b0;
        end else begin
            if (!running) begin
                running = 1'b1;
                t       = 0;
            end else begin
                t = (t + 1) % PERIOD;
            end
            if (t == 0) begin
                shadow_m = data;
                bright_m = bright;
                e.fs     = 1'b1;
            end
            r     = t / SEG;
            w     = t % SEG;
            e.idx = 3'(r);
            if (w >= BLANK) begin
                d     = w - BLANK;
                e.row = 8'(1) << r;
                if (d <= int'(bright_m)) begin
                    e.col = shadow_m[r*COLS +: COLS];
                end
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s at cycle %0d: wait expired, got timeout, expected event", name, cyc);
    endtask

    task automatic compareOut();
        exp_t e;
        if (sb.size() == 0) begin
            timeoutFail("scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        checkOutput("row_h", bus_h.row, e.row);
        checkOutput("col_h", bus_h.column, e.col);
        checkOutput("idx_h", 8'(bus_h.row_idx), 8'(e.idx));
        checkOutput("fs_h", 8'(bus_h.frame_start), 8'(e.fs));
        checkOutput("row_l", bus_l.row, ~e.row);
        checkOutput("col_l", bus_l.column, ~e.col);
        checkOutput("idx_l", 8'(bus_l.row_idx), 8'(e.idx));
        checkOutput("fs_l", 8'(bus_l.frame_start), 8'(e.fs));
    endtask

    // One clock: predict, clock, sample on the falling edge and compare.
    task automatic applyStimulus();
        sb.push_back(model_next());
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        compareOut();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
        end
    endtask

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        pwm_vec_t vecs[4];
        int       oe_cyc;
        int       fs1;
        int       fs2;
        int       lit_cyc;
        int       lit;
        int       on;
        int       k;

        vecs[0] = '{bright: 2'd0, data: 64'hFFFF_FFFF_FFFF_FFFF, exp_lit: 1, exp_col: 8'hFF};
        vecs[1] = '{bright: 2'd1, data: 64'h0000_0000_0000_00A5, exp_lit: 2, exp_col: 8'hA5};
        vecs[2] = '{bright: 2'd2, data: DIAG,                    exp_lit: 3, exp_col: 8'h01};
        vecs[3] = '{bright: 2'd3, data: 64'h0000_0000_0000_003C, exp_lit: 4, exp_col: 8'h3C};

        // Reset with scanning requested and a full bitmap.
        rstn   = 1'b0;
        oe     = 1'b1;
        data   = '1;
        bright = 2'd3;
        @(negedge CLK);
        run(3);
        checkOutput("reset_row_h", bus_h.row, 8'h00);
        checkOutput("reset_col_l", bus_l.column, 8'hFF);

        // Scan order and frame period with the diagonal pattern.
        oe   = 1'b0;
        rstn = 1'b1;
        run(2);
        data   = DIAG;
        bright = 2'd3;
        oe     = 1'b1;
        oe_cyc  = cyc;
        fs1     = -1;
        fs2     = -1;
        lit_cyc = -1;
        for (int i = 0; i < 2 * PERIOD + 2; i++) begin
            applyStimulus();
            if (bus_h.frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = cyc;
                else if (fs2 < 0) fs2 = cyc;
            end
            if (lit_cyc < 0 && bus_h.row !== 8'h00) lit_cyc = cyc;
        end
        checkOutput("first_fs_delay", 8'(fs1 - oe_cyc), 8'd1);
        checkOutput("frame_period", 8'(fs2 - fs1), 8'(PERIOD));
        checkOutput("first_lit_delay", 8'(lit_cyc - fs1), 8'(BLANK));

        // PWM duty per brightness from a vector table.
        foreach (vecs[v]) begin
            oe = 1'b0;
            applyStimulus();
            bright = vecs[v].bright;
            data   = vecs[v].data;
            oe     = 1'b1;
            run(BLANK);
            lit = 0;
            on  = 0;
            for (int d = 0; d < DWELL; d++) begin
                applyStimulus();
                if (bus_h.column === vecs[v].exp_col) lit++;
                if (bus_h.row === 8'h01) on++;
            end
            checkOutput("pwm_lit", 8'(lit), 8'(vecs[v].exp_lit));
            checkOutput("pwm_row_on", 8'(on), 8'(DWELL));
            applyStimulus();
            checkOutput("pwm_blank_after", bus_h.row, 8'h00);
        end

        // Double buffering: new data and brightness mid-frame.
        oe = 1'b0;
        applyStimulus();
        data   = DIAG;
        bright = 2'd3;
        oe     = 1'b1;
        for (k = 0; k < PERIOD && t != 12; k++) applyStimulus();
        if (t != 12) timeoutFail("dbuf_position");
        data   = 64'h0123_4567_89AB_CDEF;
        bright = 2'd1;
        for (k = 0; k < SEG && bus_h.row === 8'h00; k++) applyStimulus();
        checkOutput("dbuf_old_frame", bus_h.column, bus_h.row);
        for (k = 0; k < PERIOD && bus_h.frame_start !== 1'b1; k++) applyStimulus();
        if (bus_h.frame_start !== 1'b1) timeoutFail("dbuf_next_fs");
        run(BLANK + 1);
        checkOutput("dbuf_new_frame", bus_h.column, 8'hEF);
        run(2);
        checkOutput("dbuf_new_bright", bus_h.column, 8'h00);

        // OE drop while driving row 3, then restart with new data.
        for (k = 0; k < 2 * PERIOD && bus_h.row !== 8'h08; k++) applyStimulus();
        if (bus_h.row !== 8'h08) timeoutFail("oe_drop_wait_row3");
        run(1);
        oe   = 1'b0;
        data = 64'h0000_0000_0000_0055;
        applyStimulus();
        checkOutput("oe_drop_row", bus_h.row, 8'h00);
        checkOutput("oe_drop_idx", 8'(bus_h.row_idx), 8'd0);
        run(2);
        oe = 1'b1;
        applyStimulus();
        checkOutput("oe_restart_fs", 8'(bus_h.frame_start), 8'd1);
        run(BLANK);
        checkOutput("oe_restart_col", bus_h.column, 8'h55);
        run(SEG * 2);

        // Reset asserted on the frame-wrap edge and while OE toggles.
        for (k = 0; k < 2 * PERIOD && t != PERIOD - 1; k++) applyStimulus();
        if (t != PERIOD - 1) timeoutFail("wrap_wait");
        rstn = 1'b0;
        applyStimulus();
        checkOutput("reset_wrap_fs", 8'(bus_h.frame_start), 8'd0);
        oe = 1'b0;
        applyStimulus();
        oe = 1'b1;
        applyStimulus();
        checkOutput("reset_oe_fs", 8'(bus_h.frame_start), 8'd0);
        rstn = 1'b1;
        applyStimulus();
        checkOutput("release_fs", 8'(bus_h.frame_start), 8'd1);
        run(PERIOD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
